dmac_write_req_gen: RTL and testbench

DMAC_WRITE_REQ_GEN -- requirements
Module: dmac_write_req_gen

---
 rtl/dmac_write_req_gen.sv | 157 +++++++++++++++
 tb/tb_dmac_write_req_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_write_req_gen.sv
// DMA write-request generator: splits one write command into AXI AW bursts
// (burst-length and 4KB-page limited), tracks outstanding B responses and reports completion.
//
// state     | meaning
// IDLE      | waiting for a command
// REQ       | issuing AW bursts
// WAIT_RESP | all bursts issued, draining B responses
// DONE      | completion presented until done_ready
module dmac_write_req_gen #(
  parameter int ADDR_WD         = 32,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_WD-1:0] cmd_dst_addr,
  input  logic [1:0]         cmd_burst,
  input  logic [ADDR_WD-1:0] cmd_len,
  input  logic [2:0]         cmd_size,
  output logic               wr_req_valid,
  input  logic               wr_req_ready,
  output logic [ADDR_WD-1:0] wr_req_addr,
  output logic [1:0]         wr_req_burst,
  output logic [7:0]         wr_req_len,
  output logic [2:0]         wr_req_size,
  input  logic               wr_resp_valid,
  output logic               wr_resp_ready,
  input  logic [1:0]         wr_resp_resp,
  output logic               done_valid,
  input  logic               done_ready,
  output logic               done_err
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WD-1:0] BURST_CAP = ADDR_WD'(MAX_BURST_LEN);
  localparam logic [ADDR_WD-1:0] FIXED_CAP = ADDR_WD'((MAX_BURST_LEN < 16) ? MAX_BURST_LEN : 16);
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_WD-1:0] addr_q, addr_d;
  logic [ADDR_WD-1:0] rem_q, rem_d;
  logic [1:0]         burst_q, burst_d;
  logic [2:0]         size_q, size_d;
  logic [OW-1:0]      outst_q, outst_d;
  logic               err_q, err_d;

  logic [12:0]        page_room;
  logic [ADDR_WD-1:0] cap;
  logic [ADDR_WD-1:0] beats;
  logic               aw_hs, b_hs;

  // All outputs decode flops only, so there is no input-to-output path.
  assign cmd_ready     = (state_q == IDLE);
  assign wr_req_valid  = (state_q == REQ) && (outst_q < OW'(MAX_OUTSTANDING));
  assign wr_req_addr   = addr_q;
  assign wr_req_burst  = burst_q;
  assign wr_req_size   = size_q;
  assign wr_req_len    = 8'(beats - ADDR_WD'(1));
  assign wr_resp_ready = (state_q == REQ) || (state_q == WAIT_RESP);
  assign done_valid    = (state_q == DONE);
  assign done_err      = (state_q == DONE) && err_q;

  assign aw_hs = wr_req_valid && wr_req_ready;
  assign b_hs  = wr_resp_valid && wr_resp_ready;

  always_comb begin
    page_room = (13'h1000 - {1'b0, addr_q[11:0]}) >> size_q;
    if (burst_q == BURST_FIXED) begin
      cap = FIXED_CAP;
    end else if (ADDR_WD'(page_room) < BURST_CAP) begin
      cap = ADDR_WD'(page_room);
    end else begin
      cap = BURST_CAP;
    end
    // An address misaligned to the beat size can leave less than one beat
    // before the page end; issue a single beat rather than stalling forever.
    if (cap == '0) cap = ADDR_WD'(1);
    beats = (rem_q < cap) ? rem_q : cap;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    burst_d = burst_q;
    size_d  = size_q;
    outst_d = outst_q;
    err_d   = err_q;

    if (b_hs && (wr_resp_resp != 2'b00)) err_d = 1'b1;

    if (aw_hs && !b_hs) begin
      outst_d = outst_q + OW'(1);
    end else if (b_hs && !aw_hs && (outst_q != '0)) begin
      outst_d = outst_q - OW'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_dst_addr;
          burst_d = cmd_burst;
          rem_d   = cmd_len;
          size_d  = cmd_size;
          err_d   = 1'b0;
          if (cmd_len == '0) begin
            state_d = DONE;
          end else if (cmd_burst[1]) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (aw_hs) begin
          rem_d = rem_q - beats;
          if (burst_q != BURST_FIXED) addr_d = addr_q + (beats << size_q);
          if (rem_q == beats) state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (outst_d == '0) state_d = DONE;
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      burst_q <= '0;
      size_q  <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      burst_q <= burst_d;
      size_q  <= size_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmac_write_req_gen.sv
// Bench for dmac_write_req_gen: directed vector table, corner-case sequences
// and random commands checked against a burst-splitting reference model.
module tb_dmac_write_req_gen;

  localparam int MAX_OUT   = 2;
  localparam int MAX_BURST = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_dst_addr;
  logic [1:0]  cmd_burst;
  logic [31:0] cmd_len;
  logic [2:0]  cmd_size;
  logic        wr_req_valid;
  logic        wr_req_ready;
  logic [31:0] wr_req_addr;
  logic [1:0]  wr_req_burst;
  logic [7:0]  wr_req_len;
  logic [2:0]  wr_req_size;
  logic        wr_resp_valid;
  logic        wr_resp_ready;
  logic [1:0]  wr_resp_resp;
  logic        done_valid;
  logic        done_ready;
  logic        done_err;

  dmac_write_req_gen #(
    .ADDR_WD(32), .MAX_BURST_LEN(MAX_BURST), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dst_addr(cmd_dst_addr),
    .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_burst(wr_req_burst), .wr_req_len(wr_req_len), .wr_req_size(wr_req_size),
    .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready), .wr_resp_resp(wr_resp_resp),
    .done_valid(done_valid), .done_ready(done_ready), .done_err(done_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      addr;
    logic [1:0]       burst;
    logic [31:0]      len;
    logic [2:0]       size;
    int               bad_b;
    int               n_aw;
    logic [3:0][31:0] aw_addr;
    logic [3:0][7:0]  aw_len;
    logic             err;
  } vec_t;

  vec_t vecs[8];

  int          n_chk = 0;
  int          n_fail = 0;
  int          pending;
  logic        sent_err;
  logic        got_err;
  logic [31:0] got_addr[$];
  logic [7:0]  got_len[$];
  logic [31:0] exp_addr[$];
  logic [7:0]  exp_len[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: walk the command in plain arithmetic, one burst at a time.
  task automatic model_cmd(input logic [31:0] a0, input logic [1:0] burst,
                           input logic [31:0] len, input logic [2:0] size);
    longint rem, cap, b, a;
    exp_addr.delete();
    exp_len.delete();
    if (len == 0 || burst[1]) return;
    rem = len;
    a   = a0;
    while (rem > 0) begin
      if (burst == 2'b00) cap = 16;
      else cap = (4096 - (a % 4096)) >> size;
      if (cap > MAX_BURST) cap = MAX_BURST;
      b = (rem < cap) ? rem : cap;
      exp_addr.push_back(a[31:0]);
      exp_len.push_back(8'(b - 1));
      if (burst == 2'b01) a = (a + (b << size)) & 64'hFFFF_FFFF;
      rem -= b;
    end
  endtask

  // Called at a negedge; leaves the DUT having accepted the command.
  task automatic start_cmd(input logic [31:0] a, input logic [1:0] burst,
                           input logic [31:0] len, input logic [2:0] size);
    got_addr.delete();
    got_len.delete();
    pending  = 0;
    sent_err = 1'b0;
    got_err  = 1'bx;
    chk("cmd_ready idle", cmd_ready, 1);
    cmd_dst_addr = a;
    cmd_burst    = burst;
    cmd_len      = len;
    cmd_size     = size;
    cmd_valid    = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Acts as AW/B slave until done_valid is seen and acknowledged.
  task automatic drive_until_done(input bit rnd, input int bad_idx);
    int   b_cnt;
    logic bad, aw_hs, b_hs;
    b_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done_valid) begin
        got_err       = done_err;
        done_ready    = 1'b1;
        wr_req_ready  = 1'b0;
        wr_resp_valid = 1'b0;
        @(negedge clk);
        done_ready = 1'b0;
        return;
      end
      wr_req_ready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_resp_valid = (pending > 0) && (rnd ? ($urandom_range(0, 2) == 0) : 1'b1);
      bad = wr_resp_valid && (rnd ? ($urandom_range(0, 7) == 0) : (b_cnt == bad_idx));
      wr_resp_resp = bad ? 2'b10 : 2'b00;
      chk("outstanding cap", (pending >= MAX_OUT) && wr_req_valid, 0);
      aw_hs = wr_req_valid && wr_req_ready;
      b_hs  = wr_resp_valid && wr_resp_ready;
      if (aw_hs) begin
        got_addr.push_back(wr_req_addr);
        got_len.push_back(wr_req_len);
      end
      if (b_hs) begin
        b_cnt++;
        if (bad) sent_err = 1'b1;
      end
      pending = pending + int'(aw_hs) - int'(b_hs);
      @(negedge clk);
    end
    chk("done timeout", 0, 1);
  endtask

  task automatic check_run(input string tag, input logic exp_err);
    chk({tag, " aw count"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      chk($sformatf("%s aw%0d addr", tag, i), got_addr[i], exp_addr[i]);
      chk($sformatf("%s aw%0d len", tag, i), got_len[i], exp_len[i]);
    end
    chk({tag, " done_err"}, got_err, exp_err);
  endtask

  task automatic load_vec_exp(input int v);
    exp_addr.delete();
    exp_len.delete();
    for (int i = 0; i < vecs[v].n_aw; i++) begin
      exp_addr.push_back(vecs[v].aw_addr[i]);
      exp_len.push_back(vecs[v].aw_len[i]);
    end
  endtask

  initial begin
    logic [31:0] a, l;
    logic [1:0]  bt;
    logic [2:0]  sz;
    logic        e;
    int          r;

    vecs[0] = '{32'h1000, 2'b01, 40, 3'd2, -1, 3,
                {32'h0, 32'h1080, 32'h1040, 32'h1000}, {8'd0, 8'd7, 8'd15, 8'd15}, 1'b0};
    vecs[1] = '{32'h0FF0, 2'b01, 8, 3'd2, -1, 2,
                {32'h0, 32'h0, 32'h1000, 32'h0FF0}, {8'd0, 8'd0, 8'd3, 8'd3}, 1'b0};
    vecs[2] = '{32'h2000, 2'b00, 20, 3'd2, 1, 2,
                {32'h0, 32'h0, 32'h2000, 32'h2000}, {8'd0, 8'd0, 8'd3, 8'd15}, 1'b1};
    vecs[3] = '{32'h5000, 2'b01, 0, 3'd2, -1, 0, '0, '0, 1'b0};
    vecs[4] = '{32'h6000, 2'b10, 4, 3'd2, -1, 0, '0, '0, 1'b1};
    vecs[5] = '{32'h6000, 2'b11, 4, 3'd2, -1, 0, '0, '0, 1'b1};
    vecs[6] = '{32'hFFFF_FFC0, 2'b01, 32, 3'd2, -1, 2,
                {32'h0, 32'h0, 32'h0, 32'hFFFF_FFC0}, {8'd0, 8'd0, 8'd15, 8'd15}, 1'b0};
    vecs[7] = '{32'h3000, 2'b01, 20, 3'd0, -1, 2,
                {32'h0, 32'h0, 32'h3010, 32'h3000}, {8'd0, 8'd0, 8'd3, 8'd15}, 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_dst_addr = '0; cmd_burst = '0; cmd_len = '0; cmd_size = '0;
    wr_req_ready = 1'b0; wr_resp_valid = 1'b0; wr_resp_resp = '0; done_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst wr_req_valid", wr_req_valid, 0);
    chk("rst done_valid", done_valid, 0);
    chk("rst done_err", done_err, 0);
    chk("rst wr_resp_ready", wr_resp_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      start_cmd(vecs[v].addr, vecs[v].burst, vecs[v].len, vecs[v].size);
      drive_until_done(1'b0, vecs[v].bad_b);
      load_vec_exp(v);
      check_run($sformatf("vec%0d", v), vecs[v].err);
    end

    // Responses withheld: issue stops at the outstanding limit.
    start_cmd(32'h4000, 2'b01, 64, 3'd2);
    for (int i = 0; i < 8; i++) begin
      wr_req_ready = 1'b1;
      if (wr_req_valid) begin
        got_addr.push_back(wr_req_addr);
        got_len.push_back(wr_req_len);
        pending++;
      end
      @(negedge clk);
    end
    chk("stall aw count", got_addr.size(), MAX_OUT);
    chk("stall valid low", wr_req_valid, 0);
    wr_req_ready  = 1'b0;
    wr_resp_valid = 1'b1;
    wr_resp_resp  = 2'b00;
    if (wr_resp_ready) pending--;
    @(negedge clk);
    wr_resp_valid = 1'b0;
    chk("stall valid after B", wr_req_valid, 1);
    drive_until_done(1'b0, -1);
    model_cmd(32'h4000, 2'b01, 64, 3'd2);
    check_run("stall", sent_err);

    // Reset in the middle of a multi-burst command.
    start_cmd(32'h1000, 2'b01, 40, 3'd2);
    wr_req_ready = 1'b1;
    chk("pre-rst aw valid", wr_req_valid, 1);
    @(negedge clk);
    wr_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst wr_req_valid", wr_req_valid, 0);
    chk("mid-rst done_valid", done_valid, 0);
    chk("mid-rst done_err", done_err, 0);
    chk("mid-rst wr_resp_ready", wr_resp_ready, 0);
    rst = 1'b0;
    start_cmd(vecs[0].addr, vecs[0].burst, vecs[0].len, vecs[0].size);
    drive_until_done(1'b0, -1);
    load_vec_exp(0);
    check_run("post-rst", 1'b0);

    for (int n = 0; n < 40; n++) begin
      sz = 3'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      bt = (r < 5) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
      l  = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(1, 80));
      a  = $urandom;
      a  = a & ~((32'd1 << sz) - 32'd1);
      start_cmd(a, bt, l, sz);
      drive_until_done(1'b1, -1);
      model_cmd(a, bt, l, sz);
      e = (l == 0) ? 1'b0 : bt[1] ? 1'b1 : sent_err;
      check_run($sformatf("rand%0d", n), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
